hight_round_ctrl: RTL and testbench

//  Sequencer for one HIGHT block operation (encrypt or decrypt).

---
 rtl/hight_round_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_hight_round_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hight_round_ctrl.sv
// ---------------------------------------------------------------------------
// hight_round_ctrl
//
// Sequencer for one HIGHT block operation (encrypt or decrypt). It parks and
// primes the subkey generator, then strobes the round datapath through the
// initial whitening step, NUM_ROUNDS rounds and the final whitening step.
// Completion is reported with a start/ready/done handshake.
//
// Optional feature macro: HIGHT_CTRL_ABORT_EN
//   When defined, abort_i / aborted_o exist and a busy operation can be
//   cancelled. When undefined, an accepted operation always runs to done.
//
// Ports
//   clk          in   clock
//   reset        in   synchronous, active-high reset
//   start_i      in   operation request, accepted only while ready_o=1
//   mode_i       in   1=encrypt, 0=decrypt, sampled on an accepted start
//   abort_i      in   cancel a busy operation (HIGHT_CTRL_ABORT_EN only)
//   ready_o      out  high in IDLE
//   busy_o       out  high in LOAD, PRIME, RUN, FINAL
//   key_load_o   out  pulse on the accepted start cycle
//   sk_reset_o   out  subkey generator reset (high in IDLE and LOAD)
//   sk_ed_o      out  subkey generator direction, equals latched mode
//   init_en_o    out  initial whitening strobe (last PRIME cycle)
//   round_en_o   out  high while a round subkey is valid
//   round_num_o  out  round index 1..32 (enc) / 32..1 (dec), else 0
//   final_en_o   out  final whitening strobe
//   done_o       out  completion pulse
//   aborted_o    out  abort pulse (HIGHT_CTRL_ABORT_EN only)
// ---------------------------------------------------------------------------
module hight_round_ctrl #(
    parameter int NUM_ROUNDS   = 32,
    parameter int PRIME_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic       mode_i,
`ifdef HIGHT_CTRL_ABORT_EN
    input  logic       abort_i,
    output logic       aborted_o,
`endif
    output logic       ready_o,
    output logic       busy_o,
    output logic       key_load_o,
    output logic       sk_reset_o,
    output logic       sk_ed_o,
    output logic       init_en_o,
    output logic       round_en_o,
    output logic [5:0] round_num_o,
    output logic       final_en_o,
    output logic       done_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_PRIME = 3'd2,
        S_RUN   = 3'd3,
        S_FINAL = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [5:0] LAST_PRIME = 6'(PRIME_CYCLES - 1);
    localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);
    localparam logic [5:0] ROUNDS_V   = 6'(NUM_ROUNDS);

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       mode_q, mode_d;

    // Output registers; their next values are decoded from the next state so
    // the strobes line up with the state they describe.
    logic       ready_q, ready_d;
    logic       busy_q, busy_d;
    logic       sk_reset_q, sk_reset_d;
    logic       init_en_q, init_en_d;
    logic       round_en_q, round_en_d;
    logic [5:0] round_num_q, round_num_d;
    logic       final_en_q, final_en_d;
    logic       done_q, done_d;

    // key_load and aborted describe the current cycle's accepted event, so
    // they cannot be delayed by a register.
    logic       key_load_s;
    logic       aborted_s;

    // Next-state, counter and latched-mode logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        key_load_s = 1'b0;
        aborted_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i && !reset) begin
                    key_load_s = 1'b1;
                    mode_d     = mode_i;
                    cnt_d      = 6'd0;
                    state_d    = S_LOAD;
                end else begin
                    cnt_d = 6'd0;
                end
            end
            S_LOAD: begin
                cnt_d   = 6'd0;
                state_d = S_PRIME;
            end
            S_PRIME: begin
                if (cnt_q == LAST_PRIME) begin
                    cnt_d   = 6'd0;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_RUN: begin
                if (cnt_q == LAST_ROUND) begin
                    cnt_d   = 6'd0;
                    state_d = S_FINAL;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_FINAL: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = 6'd0;
                state_d = S_IDLE;
            end
        endcase
`ifdef HIGHT_CTRL_ABORT_EN
        // Abort only cancels busy states; IDLE and DONE ignore it.
        if (abort_i && !reset &&
            (state_q == S_LOAD || state_q == S_PRIME ||
             state_q == S_RUN  || state_q == S_FINAL)) begin
            aborted_s = 1'b1;
            cnt_d     = 6'd0;
            state_d   = S_IDLE;
        end else begin
            aborted_s = 1'b0;
        end
`endif
    end

    // Output decode from the next state, registered below.
    always_comb begin
        ready_d     = 1'b0;
        busy_d      = 1'b0;
        sk_reset_d  = 1'b0;
        init_en_d   = 1'b0;
        round_en_d  = 1'b0;
        round_num_d = 6'd0;
        final_en_d  = 1'b0;
        done_d      = 1'b0;
        case (state_d)
            S_IDLE: begin
                ready_d    = 1'b1;
                sk_reset_d = 1'b1;
            end
            S_LOAD: begin
                busy_d     = 1'b1;
                sk_reset_d = 1'b1;
            end
            S_PRIME: begin
                busy_d    = 1'b1;
                init_en_d = (cnt_d == LAST_PRIME);
            end
            S_RUN: begin
                busy_d     = 1'b1;
                round_en_d = 1'b1;
                // Encrypt walks subkeys upward, decrypt walks them downward.
                if (mode_d) begin
                    round_num_d = cnt_d + 6'd1;
                end else begin
                    round_num_d = ROUNDS_V - cnt_d;
                end
            end
            S_FINAL: begin
                busy_d     = 1'b1;
                final_en_d = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                ready_d    = 1'b1;
                sk_reset_d = 1'b1;
            end
        endcase
    end

    // State, counter, latched mode and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 6'd0;
            mode_q      <= 1'b1;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            sk_reset_q  <= 1'b1;
            init_en_q   <= 1'b0;
            round_en_q  <= 1'b0;
            round_num_q <= 6'd0;
            final_en_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            sk_reset_q  <= sk_reset_d;
            init_en_q   <= init_en_d;
            round_en_q  <= round_en_d;
            round_num_q <= round_num_d;
            final_en_q  <= final_en_d;
            done_q      <= done_d;
        end
    end

    assign ready_o     = ready_q;
    assign busy_o      = busy_q;
    assign key_load_o  = key_load_s;
    assign sk_reset_o  = sk_reset_q;
    assign sk_ed_o     = mode_q;
    assign init_en_o   = init_en_q;
    assign round_en_o  = round_en_q;
    assign round_num_o = round_num_q;
    assign final_en_o  = final_en_q;
    assign done_o      = done_q;
`ifdef HIGHT_CTRL_ABORT_EN
    assign aborted_o   = aborted_s;
`endif

endmodule

// File: tb/tb_hight_round_ctrl.sv
// ---------------------------------------------------------------------------
// Self-checking bench for hight_round_ctrl. A cycle-offset reference model
// (expected outputs as a function of cycles since the accepted start) is
// compared against every DUT output each non-reset cycle.
// ---------------------------------------------------------------------------
module tb_hight_round_ctrl;

`ifdef HIGHT_CTRL_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, start, mode, abort;
    logic       ready, busy, key_load, sk_reset, sk_ed, init_en, round_en;
    logic [5:0] round_num;
    logic       final_en, done, aborted_w;

    always #5 clk = ~clk;

    hight_round_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start),
        .mode_i     (mode),
`ifdef HIGHT_CTRL_ABORT_EN
        .abort_i    (abort),
        .aborted_o  (aborted_w),
`endif
        .ready_o    (ready),
        .busy_o     (busy),
        .key_load_o (key_load),
        .sk_reset_o (sk_reset),
        .sk_ed_o    (sk_ed),
        .init_en_o  (init_en),
        .round_en_o (round_en),
        .round_num_o(round_num),
        .final_en_o (final_en),
        .done_o     (done)
    );

`ifndef HIGHT_CTRL_ABORT_EN
    assign aborted_w = 1'b0;
`endif

    logic [15:0] obs;
    assign obs = {ready, busy, key_load, sk_reset, sk_ed, init_en, round_en,
                  round_num, final_en, done, aborted_w};

    int checks = 0;
    int errors = 0;

    // Reference model: offset d = cycles since the accepted start.
    // d=1 LOAD, d=2..3 PRIME (init at 3), d=4..35 rounds, d=36 final, d=37 done.
    int cyc   = 0;
    int t0    = 0;
    bit in_op = 1'b0;
    bit mode_m = 1'b1;

    function automatic logic [15:0] model_out();
        logic rdy, bsy, kl, skr, ie, re, fe, dn, ab;
        logic [5:0] rn;
        int d;
        rdy = 1'b0; bsy = 1'b0; kl = 1'b0; skr = 1'b0; ie = 1'b0;
        re = 1'b0; fe = 1'b0; dn = 1'b0; ab = 1'b0; rn = 6'd0;
        d = cyc - t0;
        if (!in_op) begin
            rdy = 1'b1;
            skr = 1'b1;
            kl  = start;
        end else begin
            bsy = (d <= 36);
            skr = (d == 1);
            ie  = (d == 3);
            re  = (d >= 4 && d <= 35);
            if (re) rn = mode_m ? 6'(d - 3) : 6'(36 - d);
            fe  = (d == 36);
            dn  = (d == 37);
            ab  = ABORT_EN && abort && (d <= 36);
        end
        return {rdy, bsy, kl, skr, mode_m, ie, re, rn, fe, dn, ab};
    endfunction

    task automatic model_step();
        int d;
        d = cyc - t0;
        if (reset) begin
            in_op  = 1'b0;
            mode_m = 1'b1;
        end else if (!in_op) begin
            if (start) begin
                in_op  = 1'b1;
                t0     = cyc;
                mode_m = mode;
            end
        end else if ((ABORT_EN && abort && d <= 36) || d == 37) begin
            in_op = 1'b0;
        end
        cyc++;
    endtask

    // Drive one cycle's inputs at the falling edge; outputs are sampled 1ns later.
    task automatic tick(input logic s, input logic m, input logic a, input logic r);
        @(negedge clk);
        start = s;
        mode  = m;
        abort = ABORT_EN ? a : 1'b0;
        reset = r;
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] exp;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b1);
            model_step();
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            exp = model_out();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_state t=%0t got %h want %h", $time, obs, exp);
            end
            model_step();
        end
    endtask

    task automatic test_op(input logic m, input string name);
        logic [15:0] exp;
        tick(1'b1, m, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (i > 0) tick(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            exp = model_out();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s t=%0t got %h want %h", name, $time, obs, exp);
            end
            model_step();
        end
    endtask

    task automatic test_ignore_start();
        logic [15:0] exp;
        int dn_seen;
        dn_seen = 0;
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 38; i++) begin
            if (i > 0) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            exp = model_out();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL ignore_start t=%0t got %h want %h", $time, obs, exp);
            end
            if (done === 1'b1) dn_seen++;
            model_step();
        end
        checks++;
        if (dn_seen !== 1) begin
            errors++;
            $display("FAIL ignore_start_done_count got %0d want 1", dn_seen);
        end
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            exp = model_out();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL ignore_start_drain t=%0t got %h want %h", $time, obs, exp);
            end
            model_step();
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp;
        int dn_seen;
        dn_seen = 0;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) tick(1'b0, 1'b1, 1'b0, 1'b0);
            exp = model_out();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_mid_run t=%0t got %h want %h", $time, obs, exp);
            end
            model_step();
        end
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        model_step();
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            exp = model_out();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_mid_after t=%0t got %h want %h", $time, obs, exp);
            end
            if (done === 1'b1) dn_seen++;
            model_step();
        end
        checks++;
        if (dn_seen !== 0) begin
            errors++;
            $display("FAIL reset_mid_done_count got %0d want 0", dn_seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        logic prev_done;
        prev_done = 1'b0;
        for (int i = 0; i < 3 * 38 + 2; i++) begin
            tick(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            exp = model_out();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL back_to_back t=%0t got %h want %h", $time, obs, exp);
            end
            if (prev_done) begin
                checks++;
                if (key_load !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_key_load_after_done got %b want 1", key_load);
                end
            end
            prev_done = done;
            model_step();
        end
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            model_step();
        end
    endtask

`ifdef HIGHT_CTRL_ABORT_EN
    task automatic test_abort();
        logic [15:0] exp;
        // Round 5 is offset 8; a fresh op follows and must complete.
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 90; i++) begin
            if (i > 0) tick((i == 10) ? 1'b1 : 1'b0, 1'b0, (i == 8) ? 1'b1 : 1'b0, 1'b0);
            exp = model_out();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL abort t=%0t got %h want %h", $time, obs, exp);
            end
            if (i == 9) begin
                checks++;
                if (ready !== 1'b1) begin
                    errors++;
                    $display("FAIL abort_ready_next got %b want 1", ready);
                end
            end
            model_step();
        end
    endtask
`endif

    task automatic test_random();
        logic [15:0] exp;
        logic s, m, a, r;
        for (int i = 0; i < 1500; i++) begin
            s = ($urandom_range(0, 3) == 0);
            m = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 49) == 0);
            r = ($urandom_range(0, 199) == 0);
            tick(s, m, a, r);
            if (!reset) begin
                exp = model_out();
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL random t=%0t got %h want %h", $time, obs, exp);
                end
            end
            model_step();
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        abort = 1'b0;
        test_reset();
        test_op(1'b1, "encrypt");
        test_op(1'b0, "decrypt");
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
`ifdef HIGHT_CTRL_ABORT_EN
        test_abort();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
